// File: rtl/serial_add_sub_if.sv
// Handshake/bus bundle for serial_add_sub.
//   master : requester; drives start/sub/a/b and observes the status and results
//   slave  : the serial arithmetic unit; drives busy/done/result/cout/overflow
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor.
// It uses one full-adder slice and a carry flop, and works on one bit per clock,
// LSB first. An operation takes WIDTH RUN cycles. A one-cycle done pulse follows.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   bus      serial_add_sub_if.slave
//            start/sub/a/b  request; sampled only in IDLE
//            busy           high while in RUN
//            done           one-cycle pulse; result/cout/overflow valid from here on
//            result         sum/difference mod 2^WIDTH
//            cout           carry out (for subtract, 1 = no borrow)
//            overflow       two's-complement signed overflow
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_add_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  // Bit slice
  logic s;
  logic c_nxt;

  always_comb begin
    s     = a_sh[0] ^ b_sh[0] ^ c;
    c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtract is done as a + ~b + 1. The +1 comes from the initial carry.
            a_sh   <= bus.a;
            b_sh   <= bus.sub ? ~bus.b : bus.b;
            c      <= bus.sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB. After WIDTH shifts, bit 0 is back at the LSB.
          res_sh <= {s, res_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          c      <= c_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // On this edge, c is the carry into the MSB slice. c_nxt is the carry out of it.
            cout_q <= c_nxt;
            ovf_q  <= c_nxt ^ c;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_sh;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomized checks for serial_add_sub with WIDTH = 8.
module tb_serial_add_sub;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   tot_cnt;
  int   cyc;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: {overflow, cout, result}
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic sb);
    logic [7:0] yy;
    logic [8:0] sum;
    logic       v;
    yy  = sb ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {8'd0, sb};
    v   = (x[7] == yy[7]) && (sum[7] != x[7]);
    return {v, sum[8], sum[7:0]};
  endfunction

  // Caller is at a negedge with the DUT in IDLE. The call returns at the negedge of the first IDLE cycle.
  task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic [7:0] er, input logic ec, input logic ev);
    int  n;
    int  nb;
    bit  seen;
    bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.sub = isub;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0; nb = 0; seen = 0;
    repeat (W + 6) begin
      @(negedge clk);
      n++;
      if (bus.done) begin seen = 1; break; end
      if (bus.busy) nb++;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    // The first negedge after the start edge counts as 1. done is set by the W-th RUN edge.
    chk({tag, " latency"}, 32'(n), 32'(W + 1));
    chk({tag, " busy_cycles"}, 32'(nb), 32'(W));
    chk({tag, " result"}, 32'(bus.result), 32'(er));
    chk({tag, " cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, " ovf"}, 32'(bus.overflow), 32'(ev));
    @(negedge clk);
    chk({tag, " done_drop"}, 32'(bus.done), 32'd0);
    chk({tag, " hold"}, 32'(bus.result), 32'(er));
  endtask

  initial begin
    int         pulses;
    int         last;
    bit         seen;
    logic [7:0] ca, cb;
    logic       cs;
    logic [9:0] m;

    pass_cnt = 0; tot_cnt = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst result", 32'(bus.result), 0);
    chk("rst cout", 32'(bus.cout), 0);
    chk("rst ovf", 32'(bus.overflow), 0);
    rst_n = 1'b1;

    // Add, add wrap, signed overflow
    do_op("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    do_op("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("add7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    // Subtract
    do_op("sub10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    do_op("sub80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    do_op("sub55_55", 8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

    // A start while busy is ignored, and there is only one done pulse.
    bus.start = 1'b1; bus.a = 8'h35; bus.b = 8'h4A; bus.sub = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) pulses++;
    end
    chk("ign pulses", 32'(pulses), 1);
    chk("ign result", 32'(bus.result), 32'h7F);
    chk("ign cout", 32'(bus.cout), 0);
    chk("ign ovf", 32'(bus.overflow), 0);
    chk("ign idle", 32'(bus.busy), 0);

    // A reset in the middle of a RUN aborts the operation.
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h01; bus.sub = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort busy_before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort done", 32'(bus.done), 0);
    chk("abort result", 32'(bus.result), 0);
    chk("abort cout", 32'(bus.cout), 0);
    chk("abort ovf", 32'(bus.overflow), 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("abort no_done", 32'(pulses), 0);
    do_op("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Start is held high, with new random operands for each operation.
    ca = 8'(($urandom)); cb = 8'($urandom); cs = 1'b0;
    bus.a = ca; bus.b = cb; bus.sub = cs; bus.start = 1'b1;
    last = 0;
    for (int k = 0; k < 1000; k++) begin
      seen = 0;
      repeat (W + 6) begin
        @(negedge clk);
        if (bus.done) begin seen = 1; break; end
      end
      if (!seen) begin
        chk("b2b timeout", 32'd0, 32'd1);
        break;
      end
      m = model(ca, cb, cs);
      chk("b2b result", 32'(bus.result), 32'(m[7:0]));
      chk("b2b cout", 32'(bus.cout), 32'(m[8]));
      chk("b2b ovf", 32'(bus.overflow), 32'(m[9]));
      if (k > 0) chk("b2b spacing", 32'(cyc - last), 32'(W + 2));
      last = cyc;
      ca = 8'($urandom); cb = 8'($urandom); cs = ~cs;
      bus.a = ca; bus.b = cb; bus.sub = cs;
    end
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("final idle", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
